btn_io: RTL and testbench

- Memory-mapped button input peripheral on the CPU bus, decoded by the top level at fd00-fd0f (io_addr[9:4] == 6'h10).
- Synchronises and debounces the seven board buttons.
- Latches press and release edges in sticky registers, with a maskable interrupt output for the CPU.
- Read data is registered, so it has the same one-cycle latency as the main memory read path and muxes onto cpu_din alongside it.

---
 rtl/btn_io.sv | 127 ++++++++++++
 tb/tb_btn_io.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_io.sv
`default_nettype none
// ============================================================================
// Module      : btn_io
// Description : Memory-mapped button peripheral: 2-flop sync, per-button
//               debounce, sticky press/release capture, maskable level IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_io #(
    parameter int NBTN            = 7,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CW              = 18
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [NBTN-1:0] btn,
    input  logic            en,
    input  logic            wr,
    input  logic [3:0]      addr,
    input  logic [15:0]     din,
    output logic [15:0]     dout,
    output logic            irq
);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [3:0]    c_reg_state    = 4'd0;
    localparam logic [3:0]    c_reg_pressed  = 4'd1;
    localparam logic [3:0]    c_reg_released = 4'd2;
    localparam logic [3:0]    c_reg_mask     = 4'd3;

    logic [NBTN-1:0] r_s1, r_s2, r_state, r_pressed, r_released, r_mask;
    logic [NBTN-1:0] w_accept, w_state_next, w_rise, w_fall;
    logic [NBTN-1:0] w_pressed_next, w_released_next, w_mask_next;
    logic [NBTN-1:0] w_wdata;
    logic [15:0]     w_rd_data;
    logic            w_wr, w_rd;
    logic            w_din_unused;

    assign w_wr         = en & wr;
    assign w_rd         = en & ~wr;
    assign w_wdata      = din[NBTN-1:0];
    assign w_din_unused = &{1'b0, din};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
        end
    end

    // Any sample matching the accepted level restarts the stability count.
    generate
        for (genvar i = 0; i < NBTN; i++) begin : g_debounce
            logic [CW-1:0] r_cnt;
            logic          w_diff;

            assign w_diff      = r_s2[i] ^ r_state[i];
            assign w_accept[i] = w_diff && (r_cnt == c_cnt_last);

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_cnt <= '0;
                end else if (!w_diff || w_accept[i]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end
    endgenerate

    assign w_state_next = (r_state & ~w_accept) | (r_s2 & w_accept);
    assign w_rise       = w_state_next & ~r_state;
    assign w_fall       = ~w_state_next & r_state;

    // New edges are OR-ed in after the W1C clear so a coincident event is kept.
    always_comb begin
        w_pressed_next  = r_pressed;
        w_released_next = r_released;
        w_mask_next     = r_mask;
        if (w_wr && addr == c_reg_pressed) begin
            w_pressed_next = r_pressed & ~w_wdata;
        end
        if (w_wr && addr == c_reg_released) begin
            w_released_next = r_released & ~w_wdata;
        end
        if (w_wr && addr == c_reg_mask) begin
            w_mask_next = w_wdata;
        end
        w_pressed_next  = w_pressed_next | w_rise;
        w_released_next = w_released_next | w_fall;
    end

    always_comb begin
        w_rd_data = '0;
        case (addr)
            c_reg_state:    w_rd_data[NBTN-1:0] = r_state;
            c_reg_pressed:  w_rd_data[NBTN-1:0] = r_pressed;
            c_reg_released: w_rd_data[NBTN-1:0] = r_released;
            c_reg_mask:     w_rd_data[NBTN-1:0] = r_mask;
            default:        w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= '0;
            r_pressed  <= '0;
            r_released <= '0;
            r_mask     <= '0;
            dout       <= '0;
            irq        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pressed  <= w_pressed_next;
            r_released <= w_released_next;
            r_mask     <= w_mask_next;
            irq        <= |((w_pressed_next | w_released_next) & w_mask_next);
            if (w_rd) begin
                dout <= w_rd_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_btn_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_io
// Description : Scoreboard bench for btn_io against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_io;
    localparam int NBTN = 7;
    localparam int DEB  = 8;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic [NBTN-1:0] btn = '0;
    logic            en = 1'b0;
    logic            wr = 1'b0;
    logic [3:0]      addr = '0;
    logic [15:0]     din = '0;
    logic [15:0]     dout;
    logic            irq;

    btn_io #(.NBTN(NBTN), .DEBOUNCE_CYCLES(DEB), .CW(CW)) dut (
        .clk(clk), .nreset(nreset), .btn(btn), .en(en), .wr(wr),
        .addr(addr), .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted level, consecutive-disagreement run length,
    // sticky event bits and mask, all as plain variables.
    logic [NBTN-1:0] m_s1 = '0, m_s2 = '0, m_state = '0;
    logic [NBTN-1:0] m_p = '0, m_r = '0, m_m = '0;
    int              m_run [NBTN];
    bit              m_irq = 1'b0;
    logic [15:0]     exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic e, input logic w, input logic [3:0] a, input logic [15:0] d);
        logic [NBTN-1:0] nxt;
        logic [15:0]     rv;
        if (!nreset) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_p = '0; m_r = '0; m_m = '0;
            for (int i = 0; i < NBTN; i++) m_run[i] = 0;
            m_irq = 1'b0;
            return;
        end
        if (e && !w) begin
            rv = '0;
            if (a == 0) rv[NBTN-1:0] = m_state;
            else if (a == 1) rv[NBTN-1:0] = m_p;
            else if (a == 2) rv[NBTN-1:0] = m_r;
            else if (a == 3) rv[NBTN-1:0] = m_m;
            exp_q.push_back(rv);
        end
        nxt = m_state;
        for (int i = 0; i < NBTN; i++) begin
            if (m_s2[i] == m_state[i]) m_run[i] = 0;
            else if (m_run[i] + 1 >= DEB) begin
                nxt[i] = m_s2[i];
                m_run[i] = 0;
            end else m_run[i] = m_run[i] + 1;
        end
        if (e && w && a == 1) m_p = m_p & ~d[NBTN-1:0];
        if (e && w && a == 2) m_r = m_r & ~d[NBTN-1:0];
        if (e && w && a == 3) m_m = d[NBTN-1:0];
        m_p = m_p | (nxt & ~m_state);
        m_r = m_r | (~nxt & m_state);
        m_state = nxt;
        m_s2 = m_s1;
        m_s1 = btn;
        m_irq = |((m_p | m_r) & m_m);
    endtask

    task automatic cycle(input logic e, input logic w, input logic [3:0] a, input logic [15:0] d);
        en = e; wr = w; addr = a; din = d;
        @(posedge clk);
        model_step(e, w, a, d);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'd0, 16'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b1, 1'b0, a, 16'h0);
    endtask

    task automatic wrt(input logic [3:0] a, input logic [15:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    // Monitor: a read seen on the bus at an edge makes dout the next scoreboard entry.
    logic [15:0] exp_dout = '0;
    bit          rd_seen, rst_seen;
    always begin
        @(posedge clk);
        rd_seen  = nreset && en && !wr;
        rst_seen = !nreset;
        @(negedge clk);
        if (rst_seen) begin
            exp_dout = '0;
            exp_q.delete();
        end else if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue required one entry");
            end else exp_dout = exp_q.pop_front();
        end
        check("dout", dout, exp_dout);
        check("irq", {15'h0, irq}, {15'h0, m_irq});
    end

    initial begin
        int  found;
        int  op;
        for (int i = 0; i < NBTN; i++) m_run[i] = 0;
        @(negedge clk); #1;

        // Reset held while all buttons pressed
        btn = 7'h7f;
        idle(4);
        rd(4'd0);
        nreset = 1'b1;
        idle(DEB + 4);
        rd(4'd0); rd(4'd1); rd(4'd2);

        // Release everything, clear sticky bits
        btn = '0;
        idle(DEB + 4);
        wrt(4'd1, 16'h007f); wrt(4'd2, 16'h007f);
        rd(4'd1); rd(4'd2);

        // Bounce on btn[0]: toggling every 5 cycles, then held
        for (int k = 0; k < 100; k++) begin
            if (k % 5 == 0) btn[0] = ~btn[0];
            rd(4'd0);
        end
        btn[0] = 1'b1;
        for (int k = 0; k < DEB + 6; k++) rd(4'd0);
        rd(4'd1);

        // Release and IRQ on btn[2]
        wrt(4'd3, 16'h0004);
        btn[2] = 1'b1;
        for (int k = 0; k < DEB + 5; k++) rd(4'd1);
        btn[2] = 1'b0;
        for (int k = 0; k < DEB + 5; k++) rd(4'd2);
        wrt(4'd1, 16'h0004);
        wrt(4'd2, 16'h0004);
        idle(2);

        // W1C clear coinciding with btn[1] press acceptance
        btn[1] = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (m_s2[1] != m_state[1] && m_run[1] == DEB - 1) found = 1;
            else idle(1);
        end
        n_tests++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL race_setup: got no acceptance cycle required one within 40");
        end
        wrt(4'd1, 16'h0002);
        rd(4'd1);

        // Decode and latency
        rd(4'd0); rd(4'd9);
        wrt(4'd0, 16'hffff);
        rd(4'd0);
        wrt(4'd3, 16'hffff);
        rd(4'd3);
        idle(1);
        rd(4'd15);

        // Reset in the middle of btn[3] debounce
        btn[3] = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (m_run[3] == DEB - 2) found = 1;
            else idle(1);
        end
        n_tests++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL midreset_setup: got no count of %0d required one within 40", DEB - 2);
        end
        nreset = 1'b0;
        idle(1);
        nreset = 1'b1;
        for (int k = 0; k < DEB + 6; k++) rd(4'd0);
        rd(4'd1);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 11) == 0) btn[$urandom_range(0, NBTN - 1)] ^= 1'b1;
            op = $urandom_range(0, 5);
            if (op < 2) idle(1);
            else if (op < 4) rd(4'($urandom_range(0, 5)));
            else wrt(4'($urandom_range(0, 5)), 16'($urandom));
        end

        idle(3);
        check("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
